// File: rtl/multi_counter.sv
// multi_counter: CHANNELS independent up/down counters behind one Wishbone window.
// Define MULTI_COUNTER_IRQ_EN to implement CTRL.IRQ_EN and drive irq_o; otherwise irq_o is 0.

module multi_counter #(
  parameter int          CHANNELS     = 4,
  parameter int          BITS         = 30,
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
  parameter int          DEFAULT_STEP = 1
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_ni,
  input  logic                     wbs_cyc_i,
  input  logic                     wbs_stb_i,
  input  logic                     wbs_we_i,
  input  logic [3:0]               wbs_sel_i,
  input  logic [31:0]              wbs_adr_i,
  input  logic [31:0]              wbs_dat_i,
  output logic                     wbs_ack_o,
  output logic [31:0]              wbs_dat_o,
  output logic [CHANNELS*BITS-1:0] count_o,
  output logic [CHANNELS-1:0]      irq_o
);

  localparam int EW = BITS + 9;
  localparam logic [BITS-1:0] CNT_MAX = {BITS{1'b1}};

  // Handshake: a request (cyc & stb & address in window) is accepted on an
  // edge where ack is low. Ack rises on that edge for exactly one cycle and
  // write effects commit on the same edge; the following cycle ack is forced
  // low, so a held request is re-accepted at most every second cycle.
  logic        hit;
  logic        accept;
  logic        wr_en;
  logic        ack_q;
  logic [31:0] dat_q;
  logic [31:0] rd_data;
  logic [31:0] wr_mask;
  logic [3:0]  chan_sel;
  logic [1:0]  reg_sel;

  assign hit      = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign accept   = hit & ~ack_q;
  assign wr_en    = accept & wbs_we_i;
  assign chan_sel = wbs_adr_i[7:4];
  assign reg_sel  = wbs_adr_i[3:2];
  assign wr_mask  = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};

  logic [CHANNELS-1:0][31:0] rd_count;
  logic [CHANNELS-1:0][31:0] rd_ctrl;
  logic [CHANNELS-1:0][31:0] rd_cmp;
  logic [CHANNELS-1:0][31:0] rd_stat;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic [BITS-1:0] count_q;
    logic [BITS-1:0] cmp_q;
    logic [BITS-1:0] count_step;
    logic [BITS-1:0] count_wr;
    logic [BITS-1:0] cmp_wr;
    logic [BITS-1:0] count_d;
    logic [7:0]      step_q;
    logic            en_q;
    logic            dir_q;
    logic            sat_q;
    logic            ie_q;
    logic            match_q;
    logic            ovf_q;
    logic            irq_q;
    logic            wr_ch;
    logic            ovf_hw;
    logic            match_hw;
    logic [1:0]      clr;
    logic [EW-1:0]   ext_up;
    logic [EW-1:0]   ext_dn;
    logic            unused_dn;

    assign wr_ch    = wr_en & (chan_sel == 4'(i));
    assign ext_up   = {9'd0, count_q} + {{(EW-8){1'b0}}, step_q};
    assign ext_dn   = {9'd0, count_q} - {{(EW-8){1'b0}}, step_q};
    assign count_wr = (count_q & ~wr_mask[BITS-1:0]) | (wbs_dat_i[BITS-1:0] & wr_mask[BITS-1:0]);
    assign cmp_wr   = (cmp_q & ~wr_mask[BITS-1:0]) | (wbs_dat_i[BITS-1:0] & wr_mask[BITS-1:0]);
    assign unused_dn = ^ext_dn[EW-2:BITS];

    // Out-of-range shows as any carry above BITS (up) or a borrow into the sign bit (down).
    always_comb begin
      count_step = count_q;
      ovf_hw     = 1'b0;
      if (en_q) begin
        if (dir_q) begin
          ovf_hw     = ext_dn[EW-1];
          count_step = (ovf_hw && sat_q) ? '0 : ext_dn[BITS-1:0];
        end else begin
          ovf_hw     = |ext_up[EW-1:BITS];
          count_step = (ovf_hw && sat_q) ? CNT_MAX : ext_up[BITS-1:0];
        end
      end
    end

    assign match_hw = en_q & (count_q == cmp_q);
    assign clr      = (wr_ch && reg_sel == 2'd3 && wbs_sel_i[0]) ? wbs_dat_i[1:0] : 2'b00;
    assign count_d  = (wr_ch && reg_sel == 2'd0) ? count_wr : count_step;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
        count_q <= '0;
        cmp_q   <= CNT_MAX;
        step_q  <= 8'(DEFAULT_STEP);
        en_q    <= 1'b0;
        dir_q   <= 1'b0;
        sat_q   <= 1'b0;
        match_q <= 1'b0;
        ovf_q   <= 1'b0;
      end else begin
        count_q <= count_d;
        if (wr_ch && reg_sel == 2'd2) cmp_q <= cmp_wr;
        if (wr_ch && reg_sel == 2'd1) begin
          if (wbs_sel_i[0]) begin
            en_q  <= wbs_dat_i[0];
            dir_q <= wbs_dat_i[1];
            sat_q <= wbs_dat_i[2];
          end
          if (wbs_sel_i[1]) step_q <= wbs_dat_i[15:8];
        end
        // Hardware set wins over a same-cycle W1C clear.
        match_q <= (match_q & ~clr[0]) | match_hw;
        ovf_q   <= (ovf_q & ~clr[1]) | ovf_hw;
      end
    end

`ifdef MULTI_COUNTER_IRQ_EN
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
        ie_q  <= 1'b0;
        irq_q <= 1'b0;
      end else begin
        if (wr_ch && reg_sel == 2'd1 && wbs_sel_i[0]) ie_q <= wbs_dat_i[3];
        irq_q <= match_q & ie_q;
      end
    end
`else
    assign ie_q  = 1'b0;
    assign irq_q = 1'b0;
`endif

    assign count_o[i*BITS +: BITS] = count_q;
    assign irq_o[i]    = irq_q;
    assign rd_count[i] = 32'(count_q);
    assign rd_ctrl[i]  = {16'd0, step_q, 4'd0, ie_q, sat_q, dir_q, en_q};
    assign rd_cmp[i]   = 32'(cmp_q);
    assign rd_stat[i]  = {30'd0, ovf_q, match_q};
  end

  // Channels at or above CHANNELS never match the loop and read 0.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (chan_sel == 4'(k)) begin
        case (reg_sel)
          2'd0:    rd_data = rd_count[k];
          2'd1:    rd_data = rd_ctrl[k];
          2'd2:    rd_data = rd_cmp[k];
          default: rd_data = rd_stat[k];
        endcase
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= accept;
      dat_q <= accept ? rd_data : 32'd0;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;

  logic unused_in;
  assign unused_in = ^{wbs_adr_i[1:0], wbs_dat_i, BASE_ADDR[7:0]};

endmodule

// File: tb/tb_multi_counter.sv
// Bench for multi_counter: directed scenarios plus random Wishbone traffic,
// all outputs compared every cycle against an arithmetic reference model.

module tb_multi_counter;
  localparam int     CH   = 4;
  localparam int     BITS = 30;
  localparam longint MAX  = (longint'(1) << BITS) - 1;
`ifdef MULTI_COUNTER_IRQ_EN
  localparam bit HAS_IRQ = 1'b1;
`else
  localparam bit HAS_IRQ = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cyc = 1'b0;
  logic              stb = 1'b0;
  logic              we = 1'b0;
  logic [3:0]        sel = 4'h0;
  logic [31:0]       adr = 32'h0;
  logic [31:0]       wdat = 32'h0;
  logic              ack;
  logic [31:0]       rdat;
  logic [CH*BITS-1:0] count;
  logic [CH-1:0]     irq;

  always #5 clk = ~clk;

  multi_counter #(
    .CHANNELS(CH), .BITS(BITS), .BASE_ADDR(32'h3000_0000), .DEFAULT_STEP(1)
  ) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .count_o(count), .irq_o(irq)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  longint      m_cnt[CH];
  longint      m_cmp[CH];
  int          m_step[CH];
  bit          m_en[CH], m_dir[CH], m_sat[CH], m_ie[CH];
  bit          m_match[CH], m_ovf[CH], m_irq[CH];
  bit          m_ack;
  logic [31:0] m_dat;

  function automatic logic [31:0] m_read(int c, int r);
    if (c >= CH) return 32'h0;
    case (r)
      0: return 32'(m_cnt[c]);
      1: return 32'(m_step[c] * 256 + int'(m_ie[c]) * 8 + int'(m_sat[c]) * 4 +
                    int'(m_dir[c]) * 2 + int'(m_en[c]));
      2: return 32'(m_cmp[c]);
      default: return 32'(int'(m_ovf[c]) * 2 + int'(m_match[c]));
    endcase
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_cnt[c] = 0; m_cmp[c] = MAX; m_step[c] = 1;
      m_en[c] = 0; m_dir[c] = 0; m_sat[c] = 0; m_ie[c] = 0;
      m_match[c] = 0; m_ovf[c] = 0; m_irq[c] = 0;
    end
    m_ack = 0;
    m_dat = 32'h0;
  endtask

  task automatic model_step();
    bit     acc, wr, mhw, ohw;
    int     cs, rs;
    longint mask, t, wd;
    acc  = cyc && stb && (adr[31:8] == 24'h30_0000) && !m_ack;
    cs   = int'(adr[7:4]);
    rs   = int'(adr[3:2]);
    wd   = longint'(wdat);
    mask = 0;
    for (int b = 0; b < 4; b++) if (sel[b]) mask = mask | (longint'(255) << (8 * b));
    m_dat = acc ? m_read(cs, rs) : 32'h0;
    for (int c = 0; c < CH; c++) begin
      wr       = acc && we && (c == cs);
      m_irq[c] = m_match[c] && m_ie[c];
      mhw      = m_en[c] && (m_cnt[c] == m_cmp[c]);
      ohw      = 0;
      t        = m_cnt[c];
      if (m_en[c]) begin
        t = m_dir[c] ? m_cnt[c] - m_step[c] : m_cnt[c] + m_step[c];
        if (t < 0 || t > MAX) begin
          ohw = 1;
          if (m_sat[c]) t = m_dir[c] ? 0 : MAX;
          else t = t & MAX;
        end
      end
      if (wr && rs == 0) t = ((m_cnt[c] & ~mask) | (wd & mask)) & MAX;
      if (wr && rs == 2) m_cmp[c] = ((m_cmp[c] & ~mask) | (wd & mask)) & MAX;
      if (wr && rs == 1) begin
        if (sel[0]) begin
          m_en[c] = wdat[0]; m_dir[c] = wdat[1]; m_sat[c] = wdat[2];
          m_ie[c] = HAS_IRQ && wdat[3];
        end
        if (sel[1]) m_step[c] = int'(wdat[15:8]);
      end
      if (wr && rs == 3 && sel[0]) begin
        if (wdat[0]) m_match[c] = 0;
        if (wdat[1]) m_ovf[c] = 0;
      end
      if (mhw) m_match[c] = 1;
      if (ohw) m_ovf[c] = 1;
      m_cnt[c] = t;
    end
    m_ack = acc;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) model_reset();
    else model_step();
  end

  bit mon_en = 0;
  initial forever begin
    @(negedge clk);
    if (rst_n && mon_en) begin
      logic [CH-1:0] ei;
      check("ack", ack, m_ack);
      check("dat_o", rdat, m_dat);
      for (int c = 0; c < CH; c++) begin
        ei[c] = m_irq[c];
        check($sformatf("count_ch%0d", c), count[c*BITS +: BITS], m_cnt[c]);
      end
      check("irq", irq, ei);
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [31:0] ra(int c, int r);
    return 32'h3000_0000 + 32'(c * 16 + r * 4);
  endfunction

  function automatic logic [BITS-1:0] cnt_of(int c);
    return count[c*BITS +: BITS];
  endfunction

  task automatic wb_access(input logic [31:0] a, input bit w, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd, output bit acked);
    @(negedge clk);
    adr = a; we = w; wdat = d; sel = s; cyc = 1'b1; stb = 1'b1;
    acked = 0; rd = 32'h0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (ack === 1'b1) begin
        acked = 1; rd = rdat;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd;
    bit k;
    wb_access(a, 1'b1, d, s, rd, k);
    check("wr_ack", k, 1);
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] rd);
    bit k;
    wb_access(a, 1'b0, 32'h0, 4'hF, rd, k);
    check("rd_ack", k, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rd;
    logic [31:0] rst_exp[4];
    bit          k, found;
    int          n_ack;

    rst_exp = '{32'h0, 32'h0000_0100, 32'h3FFF_FFFF, 32'h0};
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1;
    @(negedge clk);
    check("rst_ack", ack, 0);
    check("rst_dat", rdat, 0);
    check("rst_irq", irq, 0);
    check("rst_count", {63'd0, |count}, 0);

    for (int c = 0; c < CH; c++)
      for (int r = 0; r < 4; r++) begin
        wb_read(ra(c, r), rd);
        check($sformatf("rst_reg_c%0d_r%0d", c, r), rd, rst_exp[r]);
        @(negedge clk);
        check("ack_pulse", ack, 0);
      end

    // Wrap then saturate on channel 1
    wb_write(ra(1, 1), 32'h0000_0301, 4'hF);
    wb_write(ra(1, 0), 32'h3FFF_FFFE, 4'hF);
    check("ch1_written", cnt_of(1), 32'h3FFF_FFFE);
    @(negedge clk);
    check("ch1_wrap", cnt_of(1), 32'h0000_0001);
    wb_read(ra(1, 3), rd);
    check("ch1_ovf", rd & 32'h2, 32'h2);
    wb_write(ra(1, 3), 32'h3, 4'h1);
    wb_write(ra(1, 1), 32'h0000_0305, 4'hF);
    wb_write(ra(1, 0), 32'h3FFF_FFFE, 4'hF);
    @(negedge clk);
    check("ch1_sat", cnt_of(1), 32'h3FFF_FFFF);
    repeat (3) @(negedge clk);
    check("ch1_sat_hold", cnt_of(1), 32'h3FFF_FFFF);
    wb_read(ra(1, 3), rd);
    check("ch1_status", rd, 32'h3);
    wb_write(ra(1, 1), 32'h0000_0300, 4'hF);

    // Count write beats increment on channel 0
    wb_write(ra(0, 1), 32'h0000_0101, 4'hF);
    repeat (2) @(negedge clk);
    wb_write(ra(0, 0), 32'h0000_0100, 4'hF);
    check("ch0_wr_prec", cnt_of(0), 32'h100);
    @(negedge clk);
    check("ch0_next", cnt_of(0), 32'h101);

    // Compare match and interrupt on channel 2
    wb_write(ra(2, 2), 32'd10, 4'hF);
    wb_write(ra(2, 0), 32'd0, 4'hF);
    wb_write(ra(2, 1), 32'h0000_0109, 4'hF);
    found = 0;
    for (int n = 0; n < 40; n++) begin
      if (cnt_of(2) == 10) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check("ch2_reach10", found, 1);
    @(negedge clk);
    check("ch2_irq_early", irq[2], 0);
    @(negedge clk);
    check("ch2_irq", irq[2], HAS_IRQ);
    wb_read(ra(2, 3), rd);
    check("ch2_match", rd, 32'h1);
    wb_read(ra(2, 1), rd);
    check("ch2_ctrl", rd, HAS_IRQ ? 32'h0000_0109 : 32'h0000_0101);
    wb_write(ra(2, 3), 32'h1, 4'h1);
    repeat (2) @(negedge clk);
    check("ch2_irq_clr", irq[2], 0);
    wb_read(ra(2, 3), rd);
    check("ch2_match_clr", rd, 32'h0);

    // Byte lanes, absent channel, address miss
    wb_write(ra(3, 2), 32'hAABB_CCDD, 4'b0010);
    wb_read(ra(3, 2), rd);
    check("partial_cmp", rd, 32'h3FFF_CCFF);
    wb_read(ra(7, 1), rd);
    check("ch7_read", rd, 32'h0);
    wb_write(ra(7, 0), 32'h1234_5678, 4'hF);
    wb_access(32'h3000_0100, 1'b0, 32'h0, 4'hF, rd, k);
    check("miss_ack", k, 0);

    // Held request is acked every other cycle
    @(negedge clk);
    adr = ra(0, 2); we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    n_ack = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack === 1'b1) n_ack++;
    end
    cyc = 1'b0; stb = 1'b0;
    check("held_acks", n_ack, 3);

    // Random traffic against the model
    for (int c = 0; c < CH; c++)
      wb_write(ra(c, 1), 32'(($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 1) | 1), 4'hF);
    for (int it = 0; it < 300; it++) begin
      logic [31:0] a, d;
      bit          miss;
      miss = ($urandom_range(0, 15) == 0);
      a    = miss ? 32'h3000_0000 + 32'($urandom_range(1, 255) * 256)
                  : ra($urandom_range(0, 7), $urandom_range(0, 3));
      d    = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 40));
      wb_access(a, 1'($urandom_range(0, 1)), d, 4'($urandom_range(0, 15)), rd, k);
      check("rnd_ack", k, !miss);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Asynchronous reset in the middle of an acked transaction
    wb_write(ra(0, 1), 32'h0000_0001, 4'hF);
    @(negedge clk);
    adr = ra(0, 0); we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    @(posedge clk);
    #2;
    check("ack_before_rst", ack, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_ack", ack, 0);
    check("rst_mid_dat", rdat, 0);
    check("rst_mid_count", {63'd0, |count}, 0);
    check("rst_mid_irq", irq, 0);
    cyc = 1'b0; stb = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wb_read(ra(0, 1), rd);
    check("post_rst_ctrl", rd, 32'h0000_0100);
    wb_read(ra(0, 2), rd);
    check("post_rst_cmp", rd, 32'h3FFF_FFFF);
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
